dmac_burst_splitter: RTL

- Command-side stage directly upstream of the DMAC I/O register's external address channel.
- Accepts one DMA request (start byte address, length in words, direction) from the control side.
- Splits the request into bursts that never exceed MAX_BURST_LEN and never cross a 2^W_BOUNDARY_A-byte (AXI 4KB) boundary.
- Drives ext_addr / ext_read_enable / ext_write_enable / ext_word_size one burst at a time under the ext_ready handshake.

---
 rtl/dmac_burst_splitter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/dmac_burst_splitter.sv
// Splits one DMA request into bursts bounded by MAX_BURST_LEN and the 2^W_BOUNDARY_A-byte boundary,
// then issues them one at a time on the external address channel under the ext_ready handshake.
module dmac_burst_splitter #(
  parameter int W_D           = 32,
  parameter int W_EXT_A       = 32,
  parameter int W_BOUNDARY_A  = 12,
  parameter int W_BLEN        = 9,
  parameter int MAX_BURST_LEN = 256,
  parameter int W_SIZE        = 32
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [W_EXT_A-1:0] req_addr,
  input  logic [W_SIZE-1:0]  req_size,
  input  logic               req_read,
  input  logic               req_write,
  input  logic               req_valid,
  output logic               req_ready,
  output logic [W_EXT_A-1:0] ext_addr,
  output logic               ext_read_enable,
  output logic               ext_write_enable,
  output logic [W_BLEN-1:0]  ext_word_size,
  input  logic               ext_ready,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int BPW  = W_D / 8;
  localparam int OFS  = $clog2(BPW);
  localparam int CW0  = (W_SIZE > W_BOUNDARY_A + 1) ? W_SIZE : W_BOUNDARY_A + 1;
  localparam int CW   = (CW0 > W_BLEN) ? CW0 : W_BLEN;
  localparam logic [W_BOUNDARY_A:0] BND_BYTES = (W_BOUNDARY_A + 1)'(1) << W_BOUNDARY_A;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_ISSUE} state_t;

  state_t               r_state, w_state_next;
  logic [W_EXT_A-1:0]   r_addr, w_addr_next;
  logic [W_EXT_A-1:0]   r_ext_addr, w_ext_addr_next;
  logic [W_SIZE-1:0]    r_remaining, w_remaining_next;
  logic [W_BLEN-1:0]    r_blen, w_blen_next;
  logic                 r_read, w_read_next;
  logic                 r_rd_en, w_rd_en_next;
  logic                 r_wr_en, w_wr_en_next;
  logic                 r_busy, w_busy_next;
  logic                 r_done, w_done_next;
  logic                 r_err, w_err_next;

  logic [W_BOUNDARY_A:0] w_to_bnd;
  logic                  w_use_rem;
  logic                  w_use_bnd;
  logic [W_BLEN-1:0]     w_chunk;
  logic [W_SIZE-1:0]     w_rem_after;

  // Extra top bit lets a boundary-aligned address yield the full boundary span in words.
  assign w_to_bnd  = (BND_BYTES - {1'b0, r_addr[W_BOUNDARY_A-1:0]}) >> OFS;
  assign w_use_rem = (CW'(r_remaining) <= CW'(w_to_bnd)) && (CW'(r_remaining) <= CW'(MAX_BURST_LEN));
  assign w_use_bnd = CW'(w_to_bnd) <= CW'(MAX_BURST_LEN);
  assign w_chunk   = w_use_rem ? W_BLEN'(r_remaining) :
                     w_use_bnd ? W_BLEN'(w_to_bnd)    : W_BLEN'(MAX_BURST_LEN);
  assign w_rem_after = r_remaining - W_SIZE'(r_blen);

  always_comb begin
    w_state_next     = r_state;
    w_addr_next      = r_addr;
    w_ext_addr_next  = r_ext_addr;
    w_remaining_next = r_remaining;
    w_blen_next      = r_blen;
    w_read_next      = r_read;
    w_rd_en_next     = r_rd_en;
    w_wr_en_next     = r_wr_en;
    w_busy_next      = r_busy;
    w_done_next      = 1'b0;
    w_err_next       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_addr_next      = req_addr & ~W_EXT_A'(BPW - 1);
          w_remaining_next = req_size;
          w_read_next      = req_read;
          if (req_read == req_write) begin
            w_err_next = 1'b1;
          end else if (req_size == '0) begin
            w_done_next = 1'b1;
          end else begin
            w_busy_next  = 1'b1;
            w_state_next = S_CALC;
          end
        end
      end
      S_CALC: begin
        w_ext_addr_next = r_addr;
        w_blen_next     = w_chunk;
        w_rd_en_next    = r_read;
        w_wr_en_next    = ~r_read;
        w_state_next    = S_ISSUE;
      end
      S_ISSUE: begin
        // An enable is always up in this state, so ext_ready alone completes the handshake.
        if (ext_ready) begin
          w_addr_next      = r_addr + (W_EXT_A'(r_blen) << OFS);
          w_remaining_next = w_rem_after;
          w_rd_en_next     = 1'b0;
          w_wr_en_next     = 1'b0;
          if (w_rem_after == '0) begin
            w_done_next  = 1'b1;
            w_busy_next  = 1'b0;
            w_state_next = S_IDLE;
          end else begin
            w_state_next = S_CALC;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_ext_addr  <= '0;
      r_remaining <= '0;
      r_blen      <= '0;
      r_read      <= 1'b0;
      r_rd_en     <= 1'b0;
      r_wr_en     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_addr      <= w_addr_next;
      r_ext_addr  <= w_ext_addr_next;
      r_remaining <= w_remaining_next;
      r_blen      <= w_blen_next;
      r_read      <= w_read_next;
      r_rd_en     <= w_rd_en_next;
      r_wr_en     <= w_wr_en_next;
      r_busy      <= w_busy_next;
      r_done      <= w_done_next;
      r_err       <= w_err_next;
    end
  end

  assign req_ready        = (r_state == S_IDLE);
  assign ext_addr         = r_ext_addr;
  assign ext_word_size    = r_blen;
  assign ext_read_enable  = r_rd_en;
  assign ext_write_enable = r_wr_en;
  assign busy             = r_busy;
  assign done             = r_done;
  assign err              = r_err;

endmodule
